// File: rtl/be_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 4-input boolean-equation block.
// Drives all 16 input vectors in ascending order, holds each for SETTLE_CYCLES,
// samples z into a truth table and scores it against a latched expected table.
module be_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] exp_i,
    input  logic        z_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] truth_o,
    output logic [4:0]  err_cnt_o,
    output logic [3:0]  first_err_o,
    output logic        pass_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    // Final settle count before moving to the sample state.
    localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] exp_q, exp_d;
    // idx doubles as the registered {a,b,c,d} drive.
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  first_err_q, first_err_d;
    logic        pass_q, pass_d;

    // State register; rst forces IDLE and discards any sweep in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StSettle;
            StSettle: if (cnt_q == CntLast) state_d = StSample;
            StSample: state_d = (idx_q == 4'd15) ? StDone : StSettle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: latch/clear on start, count settle, capture and score samples.
    always_comb begin
        exp_d       = exp_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        truth_d     = truth_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    exp_d       = exp_i;
                    idx_d       = '0;
                    cnt_d       = '0;
                    truth_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 8'd1;
            end
            StSample: begin
                truth_d[idx_q] = z_i;
                if (z_i != exp_q[idx_q]) begin
                    err_cnt_d = err_cnt_q + 5'd1;
                    // Old count of zero means this is the lowest failing vector.
                    if (err_cnt_q == '0) first_err_d = idx_q;
                end
                // Vector 15 stays on the pins after the sweep.
                if (idx_q != 4'd15) begin
                    idx_d = idx_q + 4'd1;
                    cnt_d = '0;
                end
            end
            StDone: begin
                pass_d = (err_cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            truth_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            truth_q     <= truth_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
        a_o         = idx_q[3];
        b_o         = idx_q[2];
        c_o         = idx_q[1];
        d_o         = idx_q[0];
        truth_o     = truth_q;
        err_cnt_o   = err_cnt_q;
        first_err_o = first_err_q;
        pass_o      = pass_q;
    end

endmodule

// File: tb/tb_be_sweep_ctrl.sv
// Bench for be_sweep_ctrl: two instances (settle 2 and settle 1), each wired to a
// table-driven model of the `be` block, with randomized tables checked against
// expectations computed from the sweep timing and scoring rules.
module tb_be_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = '0;
    logic [15:0] exp_s [2];
    logic [15:0] be_tt [2];
    logic [1:0]  z, a, b, c, d, busy, done, pass;
    logic [3:0]  vec [2];
    logic [15:0] truth [2];
    logic [4:0]  err_cnt [2];
    logic [3:0]  first_err [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < 2; u++) begin : g_dut
        be_sweep_ctrl #(
            .SETTLE_CYCLES(u == 0 ? 2 : 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .start_i     (start[u]),
            .exp_i       (exp_s[u]),
            .z_i         (z[u]),
            .a_o         (a[u]),
            .b_o         (b[u]),
            .c_o         (c[u]),
            .d_o         (d[u]),
            .busy_o      (busy[u]),
            .done_o      (done[u]),
            .truth_o     (truth[u]),
            .err_cnt_o   (err_cnt[u]),
            .first_err_o (first_err[u]),
            .pass_o      (pass[u])
        );
        assign vec[u] = {a[u], b[u], c[u], d[u]};
        // Combinational `be` block described by its truth table.
        assign z[u]   = be_tt[u][vec[u]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input int u);
        check("rst_ctl", {busy[u], done[u], vec[u]}, 6'd0);
        check("rst_truth", truth[u], 16'd0);
        check("rst_score", {err_cnt[u], first_err[u], pass[u]}, 10'd0);
    endtask

    // Runs one sweep on instance u, starting at the current negedge.
    // lock: re-pulse start at T0+10 and in the DONE cycle, flip exp at T0+5.
    // abort_m >= 0: assert rst after edge T0+abort_m and stop there.
    task automatic sweep(input int u, input logic [15:0] f, input logic [15:0] e,
                         input bit lock, input int abort_m);
        int s, per, len, errs;
        logic [3:0] first, ev;
        bit seen;
        s   = (u == 0) ? 2 : 1;
        per = s + 1;
        len = 16 * per + 1;
        be_tt[u] = f;
        exp_s[u] = e;
        start[u] = 1'b1;
        for (int m = 0; m <= len; m++) begin
            @(posedge clk);
            @(negedge clk);
            start[u] = 1'b0;
            if (m == 0) begin
                check("clr_truth", truth[u], 16'd0);
                check("clr_score", {err_cnt[u], first_err[u], pass[u]}, 10'd0);
            end
            ev = (m < 16 * per) ? 4'(m / per) : 4'd15;
            check("ctl", {busy[u], done[u], vec[u]}, {m < len, m == len - 1, ev});
            if (m == abort_m) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals(u);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("post_rst", {busy[u], done[u]}, 2'd0);
                end
                return;
            end
            if (lock && m + 1 == 5)  exp_s[u] = ~e;
            if (lock && m + 1 == 10) start[u] = 1'b1;
            if (lock && m == len - 1) start[u] = 1'b1;
        end
        errs  = 0;
        first = '0;
        seen  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (f[i] != e[i]) begin
                errs++;
                if (!seen) begin
                    first = 4'(i);
                    seen  = 1'b1;
                end
            end
        end
        check("truth", truth[u], f);
        check("err_cnt", err_cnt[u], errs);
        check("first_err", first_err[u], first);
        check("pass", pass[u], errs == 0);
    endtask

    initial begin
        logic [15:0] f, e;
        int u;
        be_tt[0] = '0;
        be_tt[1] = '0;
        exp_s[0] = '0;
        exp_s[1] = '0;

        // Reset with start held high: nothing must begin.
        start = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst   = 1'b0;
        start = '0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_rst", busy, 2'd0);

        // Pass sweep, then mismatch on bits 3 and 10 back-to-back.
        f = 16'($urandom);
        sweep(0, f, f, 1'b0, -1);
        sweep(0, f, f ^ 16'h0408, 1'b0, -1);

        // Busy lockout and exp changes after acceptance.
        sweep(0, 16'($urandom), 16'($urandom), 1'b1, -1);

        // Reset while vector 5 is applied, then a full sweep.
        sweep(0, 16'($urandom), 16'($urandom), 1'b0, 16);
        f = 16'($urandom);
        sweep(0, f, f, 1'b0, -1);

        // Short settle: z stuck at 1, then stuck at 0.
        sweep(1, 16'hffff, 16'hffff, 1'b0, -1);
        sweep(1, 16'h0000, 16'hffff, 1'b0, -1);

        // Random sweeps on either instance.
        for (int k = 0; k < 6; k++) begin
            u = int'($urandom_range(0, 1));
            f = 16'($urandom);
            e = ($urandom_range(0, 2) == 0) ? f : (f ^ 16'($urandom));
            sweep(u, f, e, k[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
